warn_window_counter: RTL

WARN_WINDOW_COUNTER -- requirements
Module: warn_window_counter

---
 rtl/warn_window_counter_if.sv | 28 ++
 rtl/warn_window_counter.sv | 123 ++++++++++++
 2 files changed

// File: rtl/warn_window_counter_if.sv
// rtl/warn_window_counter_if.sv - control, sample and result signals of the warning window counter
interface warn_window_counter_if #(
  parameter int CH    = 4,
  parameter int CNT_W = 8,
  parameter int WIN_W = 16
);
  logic                start;
  logic                abort;
  logic [WIN_W-1:0]    win_len;
  logic [CNT_W-1:0]    threshold;
  logic [CH-1:0]       warning_signal;
  logic                busy;
  logic                done;
  logic [CH*CNT_W-1:0] count;
  logic [CH-1:0]       alarm;
  logic [CH-1:0]       overflow;
  logic                any_alarm;

  modport master (
    output start, abort, win_len, threshold, warning_signal,
    input  busy, done, count, alarm, overflow, any_alarm
  );

  modport slave (
    input  start, abort, win_len, threshold, warning_signal,
    output busy, done, count, alarm, overflow, any_alarm
  );
endinterface

// File: rtl/warn_window_counter.sv
// rtl/warn_window_counter.sv - counts per-channel warnings over a fixed window and flags threshold hits
module warn_window_counter #(
  parameter int CH    = 4,
  parameter int CNT_W = 8,
  parameter int WIN_W = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  warn_window_counter_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, MEASURE, DONE} state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e              state_q, state_d;
  logic [WIN_W-1:0]    win_q, win_d;
  logic [CNT_W-1:0]    thr_q, thr_d;
  logic [WIN_W-1:0]    cyc_q, cyc_d;
  logic [CH*CNT_W-1:0] live_cnt_q, live_cnt_d;
  logic [CH-1:0]       live_ovf_q, live_ovf_d;
  logic [CH*CNT_W-1:0] count_q, count_d;
  logic [CH-1:0]       alarm_q, alarm_d;
  logic [CH-1:0]       ovf_q, ovf_d;

  logic [CH*CNT_W-1:0] nxt_cnt;
  logic [CH-1:0]       nxt_ovf;
  logic [CH-1:0]       nxt_alarm;

  // Counters after this edge's sample; used both to advance and to load results on the last edge.
  always_comb begin
    nxt_cnt   = live_cnt_q;
    nxt_ovf   = live_ovf_q;
    nxt_alarm = '0;
    for (int i = 0; i < CH; i++) begin
      if (bus.warning_signal[i]) begin
        if (live_cnt_q[i*CNT_W +: CNT_W] == CNT_MAX) begin
          nxt_ovf[i] = 1'b1;
        end else begin
          nxt_cnt[i*CNT_W +: CNT_W] = live_cnt_q[i*CNT_W +: CNT_W] + CNT_W'(1);
        end
      end
      nxt_alarm[i] = (nxt_cnt[i*CNT_W +: CNT_W] >= thr_q);
    end
  end

  always_comb begin
    state_d    = state_q;
    win_d      = win_q;
    thr_d      = thr_q;
    cyc_d      = cyc_q;
    live_cnt_d = live_cnt_q;
    live_ovf_d = live_ovf_q;
    count_d    = count_q;
    alarm_d    = alarm_q;
    ovf_d      = ovf_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d    = MEASURE;
          win_d      = (bus.win_len == '0) ? WIN_W'(1) : bus.win_len;
          thr_d      = bus.threshold;
          cyc_d      = '0;
          live_cnt_d = '0;
          live_ovf_d = '0;
        end
      end
      MEASURE: begin
        // Abort wins even on the edge that would complete the window.
        if (bus.abort) begin
          state_d = IDLE;
        end else begin
          live_cnt_d = nxt_cnt;
          live_ovf_d = nxt_ovf;
          if (cyc_q == win_q - WIN_W'(1)) begin
            state_d = DONE;
            count_d = nxt_cnt;
            ovf_d   = nxt_ovf;
            alarm_d = nxt_alarm;
          end else begin
            cyc_d = cyc_q + WIN_W'(1);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      win_q      <= '0;
      thr_q      <= '0;
      cyc_q      <= '0;
      live_cnt_q <= '0;
      live_ovf_q <= '0;
      count_q    <= '0;
      alarm_q    <= '0;
      ovf_q      <= '0;
    end else begin
      state_q    <= state_d;
      win_q      <= win_d;
      thr_q      <= thr_d;
      cyc_q      <= cyc_d;
      live_cnt_q <= live_cnt_d;
      live_ovf_q <= live_ovf_d;
      count_q    <= count_d;
      alarm_q    <= alarm_d;
      ovf_q      <= ovf_d;
    end
  end

  assign bus.busy      = (state_q == MEASURE);
  assign bus.done      = (state_q == DONE);
  assign bus.count     = count_q;
  assign bus.alarm     = alarm_q;
  assign bus.overflow  = ovf_q;
  assign bus.any_alarm = |alarm_q;
endmodule
